stream_mux4_1: RTL
==================

# stream_mux4_1

Four-to-one stream collector that merges four lane streams (e.g. PE partial-sum or pooled-pixel lanes) onto a single output stream, the opposite of the one-hot 1:4 data fan-out used to distribute operands to lanes. Each input lane has a valid/ready handshake. A round-robin arbiter picks one lane per cycle, and the winning beat is registered on the output together with a one-hot tag that names its source lane. It sits between the lane array and the shared result write-back path.

## Interface
Parameters:
- size, 16, data width of every lane and of the output.
- cnt_w, 16, width of the accepted-beat counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  4  per-lane valid; bit i belongs to lane i.
- in_data1 .. in_data4  input  size each  lane 1..4 data (lane i = bit i-1 of the vectors).
- in_ready  output  4  per-lane ready; combinational.
- out_valid  output  1  output register holds a beat.
- out_data  output  size  registered beat.
- out_sel  output  4  one-hot source lane of out_data: 4'b0001 = lane 1 … 4'b1000 = lane 4.
- out_ready  input  1  downstream accepts the beat.
- beat_count  output  cnt_w  total beats accepted from all lanes; wraps modulo 2^cnt_w.

## Operation
- Input transfer on lane i: in_valid[i] && in_ready[i] at a clock edge. Output transfer: out_valid && out_ready.
- Load enable: load = !out_valid || out_ready.
- Grant (combinational, one-hot or zero):
  - Among lanes with in_valid set, pick the first at or after the lane following the last granted lane, scanning 1→2→3→4→1.
  - If no lane is valid, the grant is 4'b0000.
- in_ready = grant when load = 1, otherwise 4'b0000.
  - At most one in_ready bit is ever high.
  - in_ready depends on in_valid. Upstream must not make in_valid depend on in_ready.
- When load = 1:
  - If grant ≠ 0: out_data ← data of the granted lane, out_sel ← grant, out_valid ← 1, last-granted pointer ← grant, beat_count ← beat_count + 1.
  - If grant = 0: out_valid ← 0. out_data, out_sel and the pointer hold.
- When load = 0 (stalled): out_valid, out_data, out_sel, pointer and beat_count all hold.
- Upstream rule: once in_valid[i] is high, it stays high with stable data until that lane transfers. The block does not check this.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_sel = 4'b0000, beat_count = 0. The pointer resets to lane 4, so lane 1 has first priority.
- in_ready during reset is 4'b0000: load is forced low while reset is high.
- Latency: an input beat appears on out_data 1 cycle after its transfer edge.
- Throughput: 1 beat/cycle while out_ready stays high.
- Full backpressure (out_valid=1, out_ready=0): all in_ready=0. out_data and out_sel stay stable until the output transfer.
- Simultaneous output transfer and new input transfer in the same cycle are allowed; this is the normal streaming case.
- All four lanes valid continuously: grant order 1,2,3,4,1,… with no lane granted twice in any 4 consecutive transfers.
- Single valid lane: that lane is granted every cycle regardless of the pointer.
- beat_count at 2^cnt_w−1 followed by a transfer → 0. No flag is raised.
- Reset mid-operation: a beat held in the output register is discarded (out_valid → 0). Upstream must re-present any lane whose beat had not yet transferred.

## Structure
- Shared package cnn_stream_pkg holds:
  - LANES = 4.
  - One-hot lane constants LANE1 = 4'b0001 … LANE4 = 4'b1000, shared with the 1:4 distribution side so select and tag encodings match.
- Sub-module rr_arbiter4: purely combinational. Inputs are the 4-bit request and the 4-bit one-hot last-grant; output is the one-hot grant.
  - The pointer register lives in stream_mux4_1.
- Top level holds the output register, the data mux (one-hot AND-OR), the pointer and beat_count.

## Test plan
- Reset: assert reset 2 cycles with in_valid=4'b1111 → out_valid=0, out_sel=4'b0000, in_ready=4'b0000, beat_count=0.
- Round-robin: all lanes valid, in_data1..4 = 16'h0011/0022/0033/0044, out_ready=1 for 8 cycles → out_data sequence 0011,0022,0033,0044,0011,0022,0033,0044; out_sel 0001,0010,0100,1000 repeating; beat_count=8.
- Backpressure: lane 3 sends 16'hBEEF, then out_ready=0 for 3 cycles with lanes 1 and 2 valid → out_data=BEEF, out_sel=4'b0100 held, in_ready=0. On release, the next beat is lane 4 if valid, otherwise lane 1.
- Sparse: only lane 2 valid for 3 consecutive cycles → 3 beats tagged 4'b0010. Then no lanes valid → out_valid drops to 0 one cycle after the last transfer.
- Wrap: cnt_w=4, 17 transfers → beat_count=1.
- Mid-stream reset: reset asserted while out_valid=1, out_ready=0 → next cycle out_valid=0, beat_count=0. The first grant after release goes to lane 1.

Source files
------------

// File: rtl/cnn_stream_pkg.sv
// Shared lane definitions for the CNN stream fan-out/collect blocks.
// One-hot lane constants keep select and tag encodings identical on both sides.
package cnn_stream_pkg;

    localparam int LANES = 4;

    typedef logic [LANES-1:0] lane_vec_t;

    localparam lane_vec_t LANE1 = 4'b0001;
    localparam lane_vec_t LANE2 = 4'b0010;
    localparam lane_vec_t LANE3 = 4'b0100;
    localparam lane_vec_t LANE4 = 4'b1000;

    // Index of the set bit in a one-hot lane vector; an empty vector maps to
    // lane 4 so that scanning resumes at lane 1.
    function automatic logic [1:0] lane_index(input lane_vec_t onehot);
        lane_index = 2'd3;
        for (int i = 0; i < LANES; i++) begin
            if (onehot[i]) begin
                lane_index = 2'(i);
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: first requester at or after the
// lane following the last grant wins.
module rr_arbiter4
    import cnn_stream_pkg::*;
(
    input  lane_vec_t req,
    input  lane_vec_t last_grant,
    output lane_vec_t grant
);

    logic [1:0] start_idx;
    logic [1:0] scan_idx;
    logic       found;

    always_comb begin
        grant     = '0;
        found     = 1'b0;
        scan_idx  = '0;
        start_idx = lane_index(last_grant) + 2'd1;
        for (int k = 0; k < LANES; k++) begin
            scan_idx = start_idx + 2'(k);
            if (!found && req[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux4_1.sv
// Four-lane to one stream collector: round-robin pick, registered beat with a
// one-hot source tag, and a running count of accepted beats.
module stream_mux4_1
    import cnn_stream_pkg::*;
#(
    parameter int size  = 16,
    parameter int cnt_w = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        in_valid,
    input  logic [size-1:0]   in_data1,
    input  logic [size-1:0]   in_data2,
    input  logic [size-1:0]   in_data3,
    input  logic [size-1:0]   in_data4,
    output logic [3:0]        in_ready,
    output logic              out_valid,
    output logic [size-1:0]   out_data,
    output logic [3:0]        out_sel,
    input  logic              out_ready,
    output logic [cnt_w-1:0]  beat_count
);

    logic [size-1:0]  lane_data [LANES];
    logic [size-1:0]  mux_data;
    lane_vec_t        grant;
    lane_vec_t        last_grant;
    logic             load;

    logic             vld_p0;
    logic [size-1:0]  data_p0;
    lane_vec_t        sel_p0;
    logic [cnt_w-1:0] count;

    assign lane_data[0] = in_data1;
    assign lane_data[1] = in_data2;
    assign lane_data[2] = in_data3;
    assign lane_data[3] = in_data4;

    // Reset blocks loading so no lane sees ready while the block is held.
    assign load     = !reset && (!vld_p0 || out_ready);
    assign in_ready = load ? grant : '0;

    rr_arbiter4 u_arb (
        .req        (in_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < LANES; i++) begin
            mux_data = mux_data | ({size{grant[i]}} & lane_data[i]);
        end
    end

    // Stage p0: output register, pointer and beat counter
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0     <= 1'b0;
            data_p0    <= '0;
            sel_p0     <= '0;
            last_grant <= LANE4;
            count      <= '0;
        end else if (load) begin
            if (|grant) begin
                vld_p0     <= 1'b1;
                data_p0    <= mux_data;
                sel_p0     <= grant;
                last_grant <= grant;
                count      <= count + 1'b1;
            end else begin
                vld_p0 <= 1'b0;
            end
        end
    end

    assign out_valid  = vld_p0;
    assign out_data   = data_p0;
    assign out_sel    = sel_p0;
    assign beat_count = count;

endmodule
